// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the TMDS PLL reset, qualifies its lock output
// and releases a synchronous reset / ready flag to downstream video logic.
// Lock timeouts and lock losses are counted (saturating) for debug.

module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned PLL_RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 270000,
  parameter int unsigned STABLE_CYCLES    = 27000,
  parameter int unsigned CNT_WIDTH        = 20,
  parameter int unsigned EVT_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lock,
  output logic                 pll_reset,
  output logic                 sys_rst,
  output logic                 ready,
  output logic [EVT_WIDTH-1:0] retry_count,
  output logic [EVT_WIDTH-1:0] lost_count
);

  typedef enum logic [1:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun
  } state_e;

  // Terminal counts for each timed state.
  localparam logic [CNT_WIDTH-1:0] RstLast    = CNT_WIDTH'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LockLast   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] StableLast = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);
  localparam logic [EVT_WIDTH-1:0] EvtOne     = EVT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [EVT_WIDTH-1:0]   retry_q, retry_d;
  logic [EVT_WIDTH-1:0]   lost_q, lost_d;

  // Lock synchroniser; the raw lock input is used nowhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state, shared counter and event-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    unique case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StResetPll;
          cnt_d   = '0;
          if (retry_q != '1) begin
            retry_d = retry_q + EvtOne;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStable: begin
        // Any captured dropout restarts qualification via WAIT_LOCK.
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = StResetPll;
          if (lost_q != '1) begin
            lost_d = lost_q + EvtOne;
          end
        end
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output always matches a decode of the current state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StResetPll;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_reset <= (state_d == StResetPll);
      sys_rst   <= (state_d != StRun);
      ready     <= (state_d == StRun);
    end
  end

  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with short timing parameters.

module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       pll_reset, sys_rst, ready;
  logic [7:0] retry_count, lost_count;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    logic [18:0] val;
    string       tag;
  } exp_t;

  typedef struct {
    int   at;
    logic r;
    logic l;
  } stim_t;

  exp_t  sb[$];
  stim_t stim[$];

  pll_lock_supervisor #(
    .SYNC_STAGES     (2),
    .PLL_RESET_CYCLES(4),
    .LOCK_TIMEOUT    (100),
    .STABLE_CYCLES   (16),
    .CNT_WIDTH       (20),
    .EVT_WIDTH       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock       (lock),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retry_count(retry_count),
    .lost_count (lost_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Applies scheduled rst/lock values just after the edge numbered 'at'.
  initial begin
    forever begin
      @(negedge clk);
      while (stim.size() != 0 && stim[0].at <= cyc) begin
        rst  = stim[0].r;
        lock = stim[0].l;
        void'(stim.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_stim(input int at, input logic r, input logic l);
    stim_t s;
    s.at = at;
    s.r  = r;
    s.l  = l;
    stim.push_back(s);
  endtask

  task automatic push_exp(input int due, input logic pr, input logic sr, input logic rd,
                          input logic [7:0] rc, input logic [7:0] lc, input string tag);
    exp_t e;
    e.due = due;
    e.val = {pr, sr, rd, rc, lc};
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Asserts rst for one edge with lock at the given level; returns that edge number.
  task automatic do_reset(input logic l, output int r);
    int t;
    t = cyc;
    push_stim(t + 1, 1'b1, l);
    push_stim(t + 2, 1'b0, l);
    r = t + 2;
    while (cyc < r) @(negedge clk);
  endtask

  task automatic test_reset();
    int r;
    exp_t e;
    logic [18:0] obs;
    do_reset(1'b0, r);
    for (int k = 0; k < 4; k++) push_exp(r + k, 1, 1, 0, 0, 0, "rst_pll_high");
    push_exp(r + 4, 0, 1, 0, 0, 0, "rst_pll_fall");
    push_exp(r + 10, 0, 1, 0, 0, 0, "rst_wait_lock");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cyc > e.due) begin
        bad++;
        $display("FAIL %s: late check at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        while (cyc < e.due) @(negedge clk);
        obs = {pll_reset, sys_rst, ready, retry_count, lost_count};
        if (obs !== e.val) begin
          bad++;
          $display("FAIL %s @%0d: got %05h want %05h", e.tag, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_lock_ready();
    int r;
    exp_t e;
    logic [18:0] obs;
    do_reset(1'b0, r);
    push_stim(r + 14, 1'b0, 1'b1);
    push_exp(r + 32, 0, 1, 0, 0, 0, "lock_not_yet");
    push_exp(r + 33, 0, 0, 1, 0, 0, "lock_ready");
    push_exp(r + 40, 0, 0, 1, 0, 0, "lock_run_hold");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cyc > e.due) begin
        bad++;
        $display("FAIL %s: late check at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        while (cyc < e.due) @(negedge clk);
        obs = {pll_reset, sys_rst, ready, retry_count, lost_count};
        if (obs !== e.val) begin
          bad++;
          $display("FAIL %s @%0d: got %05h want %05h", e.tag, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int r;
    exp_t e;
    logic [18:0] obs;
    do_reset(1'b0, r);
    push_exp(r + 103, 0, 1, 0, 0, 0, "to_last_wait");
    push_exp(r + 104, 1, 1, 0, 1, 0, "to_retry1");
    push_exp(r + 107, 1, 1, 0, 1, 0, "to_pll_hold");
    push_exp(r + 108, 0, 1, 0, 1, 0, "to_pll_fall");
    push_exp(r + 104 * 255 - 1, 0, 1, 0, 254, 0, "to_retry254");
    push_exp(r + 104 * 255, 1, 1, 0, 255, 0, "to_retry255");
    push_exp(r + 104 * 256, 1, 1, 0, 255, 0, "to_sat_hold");
    push_exp(r + 104 * 300 + 5, 0, 1, 0, 255, 0, "to_sat_300");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cyc > e.due) begin
        bad++;
        $display("FAIL %s: late check at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        while (cyc < e.due) @(negedge clk);
        obs = {pll_reset, sys_rst, ready, retry_count, lost_count};
        if (obs !== e.val) begin
          bad++;
          $display("FAIL %s @%0d: got %05h want %05h", e.tag, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int r;
    exp_t e;
    logic [18:0] obs;
    do_reset(1'b0, r);
    push_stim(r + 14, 1'b0, 1'b1);
    // One-cycle dropout reaching the FSM while the stable count is 10.
    push_stim(r + 25, 1'b0, 1'b0);
    push_stim(r + 26, 1'b0, 1'b1);
    push_exp(r + 33, 0, 1, 0, 0, 0, "gl_no_ready_orig");
    push_exp(r + 44, 0, 1, 0, 0, 0, "gl_not_yet");
    push_exp(r + 45, 0, 0, 1, 0, 0, "gl_ready");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cyc > e.due) begin
        bad++;
        $display("FAIL %s: late check at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        while (cyc < e.due) @(negedge clk);
        obs = {pll_reset, sys_rst, ready, retry_count, lost_count};
        if (obs !== e.val) begin
          bad++;
          $display("FAIL %s @%0d: got %05h want %05h", e.tag, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int r;
    exp_t e;
    logic [18:0] obs;
    do_reset(1'b0, r);
    push_stim(r + 14, 1'b0, 1'b1);
    push_stim(r + 40, 1'b0, 1'b0);
    push_stim(r + 50, 1'b0, 1'b1);
    push_exp(r + 42, 0, 0, 1, 0, 0, "loss_still_run");
    push_exp(r + 43, 1, 1, 0, 0, 1, "loss_reset");
    push_exp(r + 47, 0, 1, 0, 0, 1, "loss_pll_fall");
    push_exp(r + 68, 0, 1, 0, 0, 1, "loss_not_yet");
    push_exp(r + 69, 0, 0, 1, 0, 1, "loss_ready_again");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cyc > e.due) begin
        bad++;
        $display("FAIL %s: late check at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        while (cyc < e.due) @(negedge clk);
        obs = {pll_reset, sys_rst, ready, retry_count, lost_count};
        if (obs !== e.val) begin
          bad++;
          $display("FAIL %s @%0d: got %05h want %05h", e.tag, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int r;
    int b;
    exp_t e;
    logic [18:0] obs;
    do_reset(1'b0, r);
    // One timeout first so the reset of retry_count is observable.
    push_exp(r + 104, 1, 1, 0, 1, 0, "b2b_retry1");
    push_stim(r + 110, 1'b0, 1'b1);
    push_exp(r + 128, 0, 1, 0, 1, 0, "b2b_not_yet");
    push_exp(r + 129, 0, 0, 1, 1, 0, "b2b_run");
    for (int i = 0; i < 3; i++) begin
      b = r + 140 + 40 * i;
      push_stim(b, 1'b0, 1'b0);
      push_stim(b + 10, 1'b0, 1'b1);
      push_exp(b + 3, 1, 1, 0, 1, 8'(i + 1), "b2b_loss");
      push_exp(b + 29, 0, 0, 1, 1, 8'(i + 1), "b2b_rerun");
    end
    push_stim(r + 260, 1'b1, 1'b1);
    push_stim(r + 261, 1'b0, 1'b1);
    push_exp(r + 260, 0, 0, 1, 1, 3, "b2b_pre_rst");
    push_exp(r + 261, 1, 1, 0, 0, 0, "b2b_rst_run");
    push_exp(r + 264, 1, 1, 0, 0, 0, "b2b_rst_pll_hold");
    push_exp(r + 265, 0, 1, 0, 0, 0, "b2b_rst_pll_fall");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cyc > e.due) begin
        bad++;
        $display("FAIL %s: late check at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else begin
        while (cyc < e.due) @(negedge clk);
        obs = {pll_reset, sys_rst, ready, retry_count, lost_count};
        if (obs !== e.val) begin
          bad++;
          $display("FAIL %s @%0d: got %05h want %05h", e.tag, cyc, obs, e.val);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock_ready();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
